// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM address/data, decode-side instruction outputs and sequencing controls.
// FETCH_BRANCH_REL_EN adds the relative-branch signals BranchRel and BranchOffset.
interface instr_fetch_if;
  logic        Start;
  logic        Stall;
  logic        BranchEn;
  logic [11:0] BranchTarget;
`ifdef FETCH_BRANCH_REL_EN
  logic [7:0]  BranchOffset;
  logic        BranchRel;
`endif
  logic [8:0]  InstrIn;
  logic [11:0] InstAddress;
  logic [8:0]  Instr;
  logic [11:0] InstrPC;
  logic        InstrValid;
  logic        Done;

  // master: the fetch unit itself
  modport master (
    input  Start, Stall, BranchEn, BranchTarget,
`ifdef FETCH_BRANCH_REL_EN
    input  BranchOffset, BranchRel,
`endif
    input  InstrIn,
    output InstAddress, Instr, InstrPC, InstrValid, Done
  );

  // slave: ROM plus decode/execute environment
  modport slave (
    output Start, Stall, BranchEn, BranchTarget,
`ifdef FETCH_BRANCH_REL_EN
    output BranchOffset, BranchRel,
`endif
    output InstrIn,
    input  InstAddress, Instr, InstrPC, InstrValid, Done
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, registers ROM words for decode, handles start/halt/stall/branch.
// Optional `define FETCH_BRANCH_REL_EN enables InstrPC-relative branches via BranchRel/BranchOffset.
module instr_fetch #(
  parameter logic [11:0] START_ADDR = 12'h000,
  parameter logic [8:0]  HALT_WORD  = 9'h1FF
) (
  input logic           Clk,
  input logic           Reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t      state;
  logic [11:0] pc_p0;
  logic [8:0]  instr_p1;
  logic [11:0] instr_pc_p1;
  logic        vld_p1;
  logic        done_q;
  logic [11:0] target;

`ifdef FETCH_BRANCH_REL_EN
  function automatic logic [11:0] rel_target(input logic [11:0] base,
                                             input logic signed [7:0] off);
    logic signed [11:0] off_ext;
    off_ext = 12'(off);
    return base + off_ext;
  endfunction

  assign target = bus.BranchRel ? rel_target(instr_pc_p1, bus.BranchOffset)
                                : bus.BranchTarget;
`else
  assign target = bus.BranchTarget;
`endif

  // p0: PC drives the ROM; p1: captured word, its address and validity
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pc_p0       <= START_ADDR;
      instr_p1    <= 9'h000;
      instr_pc_p1 <= 12'h000;
      vld_p1      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (bus.Start) begin
            state  <= RUN;
            pc_p0  <= START_ADDR;
            vld_p1 <= 1'b0;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.BranchEn) begin
            // word fetched this cycle belongs to the wrong path; drop it
            pc_p0  <= target;
            vld_p1 <= 1'b0;
          end else if (!bus.Stall) begin
            instr_p1    <= bus.InstrIn;
            instr_pc_p1 <= pc_p0;
            if (bus.InstrIn == HALT_WORD) begin
              vld_p1 <= 1'b0;
              done_q <= 1'b1;
              state  <= HALTED;
            end else begin
              vld_p1 <= 1'b1;
              pc_p0  <= pc_p0 + 12'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.InstAddress = pc_p0;
  assign bus.Instr       = instr_p1;
  assign bus.InstrPC     = instr_pc_p1;
  assign bus.InstrValid  = vld_p1;
  assign bus.Done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then randomized traffic vs a behavioural model.
module tb_instr_fetch;
  localparam int START = 0;
  localparam int HALT  = 'h1FF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus();
  logic [8:0] rom [0:4095];
  assign bus.InstrIn = rom[bus.InstAddress];

  instr_fetch #(.START_ADDR(12'h000), .HALT_WORD(9'h1FF)) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: program state expressed as plain integers
  int m_mode;  // 0 idle, 1 running, 2 halted
  int m_pc, m_instr, m_ipc, m_vld, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = START; m_instr = 0; m_ipc = 0; m_vld = 0; m_done = 0;
  endtask

  function automatic int branch_dest();
    int t;
    t = int'(bus.BranchTarget);
`ifdef FETCH_BRANCH_REL_EN
    if (bus.BranchRel) t = (m_ipc + int'($signed(bus.BranchOffset))) & 'hFFF;
`endif
    return t;
  endfunction

  task automatic model_step();
    int word;
    if (m_mode != 1) begin
      if (bus.Start) begin
        m_mode = 1; m_pc = START; m_vld = 0; m_done = 0;
      end
    end else begin
      word = int'(rom[m_pc]);
      if (bus.BranchEn) begin
        m_pc = branch_dest(); m_vld = 0;
      end else if (!bus.Stall) begin
        m_instr = word; m_ipc = m_pc;
        if (word == HALT) begin
          m_vld = 0; m_done = 1; m_mode = 2;
        end else begin
          m_vld = 1; m_pc = (m_pc + 1) % 4096;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  32'(bus.InstAddress), 32'(m_pc));
    chk({tag, ".instr"}, 32'(bus.Instr),       32'(m_instr));
    chk({tag, ".ipc"},   32'(bus.InstrPC),     32'(m_ipc));
    chk({tag, ".vld"},   32'(bus.InstrValid),  32'(m_vld));
    chk({tag, ".done"},  32'(bus.Done),        32'(m_done));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic s, input logic st, input logic br, input logic [11:0] t);
    bus.Start = s; bus.Stall = st; bus.BranchEn = br; bus.BranchTarget = t;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 9'($urandom_range(0, 'h1FE));
    for (int a = 0; a < 4; a++) rom[a] = 9'(a + 1);
    rom[4] = 9'h1FF;
    rom[12'hFFF] = 9'h00A;
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
`ifdef FETCH_BRANCH_REL_EN
    bus.BranchRel = 1'b0; bus.BranchOffset = 8'h00;
`endif

    // reset state
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("reset");
    @(posedge clk); #1 rst = 1'b0;
    step("idle");
    set_in(1'b0, 1'b1, 1'b1, 12'h123);
    step("idle_ignore");

    // 1: straight-line run to halt
    set_in(1'b1, 1'b0, 1'b0, 12'h000);
    step("start1");
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    for (int i = 1; i <= 4; i++) begin
      step("run1");
      chk("run1.seq", 32'(bus.Instr), 32'(i));
    end
    step("halt");
    chk("halt.done", 32'(bus.Done), 32'd1);
    chk("halt.pc", 32'(bus.InstAddress), 32'd4);
    set_in(1'b0, 1'b1, 1'b1, 12'h050);
    step("halted_hold");
    chk("halted.pc", 32'(bus.InstAddress), 32'd4);

    // 2: stall
    set_in(1'b1, 1'b0, 1'b0, 12'h000);
    step("restart");
    chk("restart.done", 32'(bus.Done), 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 12'h000);
    step("run2");
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    step("run2");
    chk("run2.instr2", 32'(bus.Instr), 32'h002);
    set_in(1'b0, 1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.ipc", 32'(bus.InstrPC), 32'd1);
      chk("stall.pc", 32'(bus.InstAddress), 32'd2);
    end
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    step("resume");
    chk("resume.instr", 32'(bus.Instr), 32'h003);

    // 3: branch with simultaneous stall
    set_in(1'b0, 1'b1, 1'b1, 12'h100);
    step("br");
    chk("br.squash", 32'(bus.InstrValid), 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    step("br_tgt");
    chk("br_tgt.ipc", 32'(bus.InstrPC), 32'h100);
    chk("br_tgt.instr", 32'(bus.Instr), 32'(rom[12'h100]));
    // halt word in a squashed slot is discarded
    set_in(1'b0, 1'b0, 1'b1, 12'h004);
    step("br_to_halt");
    set_in(1'b0, 1'b0, 1'b1, 12'h200);
    step("squash_halt");
    chk("squash_halt.done", 32'(bus.Done), 32'd0);

    // 4: PC wrap
    set_in(1'b0, 1'b0, 1'b1, 12'hFFE);
    step("wrap_br");
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    step("wrap");
    step("wrap");
    chk("wrap.instr", 32'(bus.Instr), 32'h00A);
    chk("wrap.ipc", 32'(bus.InstrPC), 32'hFFF);
    chk("wrap.addr", 32'(bus.InstAddress), 32'h000);

    // 5: async reset mid-run
    set_in(1'b0, 1'b0, 1'b1, 12'h030);
    step("rst_br");
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 7; i++) step("to37");
    chk("to37.pc", 32'(bus.InstAddress), 32'h037);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk); #1 rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 12'h000);
    step("rst_start");
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    step("rst_run");
    chk("rst_run.instr", 32'(bus.Instr), 32'h001);

`ifdef FETCH_BRANCH_REL_EN
    // 6: relative branches
    set_in(1'b0, 1'b0, 1'b1, 12'h010);
    step("rel_setup");
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    step("rel_setup");
    chk("rel.ipc10", 32'(bus.InstrPC), 32'h010);
    set_in(1'b0, 1'b0, 1'b1, 12'h777);
    bus.BranchRel = 1'b1; bus.BranchOffset = 8'hFC;
    step("rel_back");
    chk("rel_back.pc", 32'(bus.InstAddress), 32'h00C);
    bus.BranchRel = 1'b0;
    set_in(1'b0, 1'b0, 1'b1, 12'h000);
    step("rel_setup0");
    set_in(1'b0, 1'b0, 1'b0, 12'h000);
    step("rel_setup0");
    set_in(1'b0, 1'b0, 1'b1, 12'h555);
    bus.BranchRel = 1'b1; bus.BranchOffset = 8'hFF;
    step("rel_wrap");
    chk("rel_wrap.pc", 32'(bus.InstAddress), 32'hFFF);
    bus.BranchRel = 1'b0;
`endif

    // randomized traffic, with a few halt words sprinkled in
    for (int i = 0; i < 12; i++) rom[$urandom_range(5, 4095)] = 9'h1FF;
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 9) == 0), 12'($urandom));
`ifdef FETCH_BRANCH_REL_EN
      bus.BranchRel = 1'($urandom); bus.BranchOffset = 8'($urandom);
`endif
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
